// File: rtl/rv32i_wbck_ctrl.sv
// rv32i_wbck_ctrl
//   Producer side of the register-file write port. Each cycle, one result is picked:
//   the long-latency channel (LSU, mul/div) wins over the single-cycle ALU channel.
//   The winner is registered onto the write port.
//   A pending-destination scoreboard tracks issued long-latency ops, so decode can see
//   RAW/WAW hazards. An outstanding counter caps how many such ops are in flight.
module rv32i_wbck_ctrl #(
  parameter int WORD_WTH    = 32,
  parameter int REG_INX_WTH = 5,
  parameter int REG_NUM     = 32,
  parameter int LNG_OSTD    = 4,
  parameter int CNT_WTH     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  // single-cycle ALU result channel
  input  logic                   alu_wbck_valid,
  output logic                   alu_wbck_ready,
  input  logic [REG_INX_WTH-1:0] alu_wbck_idx,
  input  logic [WORD_WTH-1:0]    alu_wbck_dat,
  // long-latency result channel
  input  logic                   lng_wbck_valid,
  output logic                   lng_wbck_ready,
  input  logic [REG_INX_WTH-1:0] lng_wbck_idx,
  input  logic [WORD_WTH-1:0]    lng_wbck_dat,
  // long-latency issue
  input  logic                   lng_issue_valid,
  output logic                   lng_issue_ready,
  input  logic [REG_INX_WTH-1:0] lng_issue_idx,
  // decode hazard check
  input  logic [REG_INX_WTH-1:0] chk_src1_idx,
  input  logic [REG_INX_WTH-1:0] chk_src2_idx,
  input  logic [REG_INX_WTH-1:0] chk_dest_idx,
  output logic                   chk_hazard,
  output logic [CNT_WTH-1:0]     lng_ostd_cnt,
  // regfile write port
  output logic                   wbck_dest_wen,
  output logic [REG_INX_WTH-1:0] wbck_dest_idx,
  output logic [WORD_WTH-1:0]    wbck_dest_dat
);

  localparam logic [CNT_WTH-1:0]     CNT_LIMIT = CNT_WTH'(LNG_OSTD);
  localparam logic [CNT_WTH-1:0]     CNT_ONE   = CNT_WTH'(1);
  localparam logic [REG_INX_WTH-1:0] IDX_ZERO  = {REG_INX_WTH{1'b0}};

  // Returns 1 when 'idx' is pending. Register x0 is never reported as pending.
  function automatic logic pend_hit(input logic [REG_NUM-1:0]     vec,
                                    input logic [REG_INX_WTH-1:0] idx);
    logic hit;
    if (idx == IDX_ZERO) begin
      hit = 1'b0;
    end else begin
      hit = vec[idx];
    end
    return hit;
  endfunction

  logic [REG_NUM-1:0]     pending_r;
  logic [REG_NUM-1:0]     pending_nxt_s;
  logic [REG_NUM-1:0]     set_vec_s;
  logic [REG_NUM-1:0]     clr_vec_s;
  logic [CNT_WTH-1:0]     cnt_r;
  logic [CNT_WTH-1:0]     cnt_nxt_s;
  logic                   lng_xfer_s;
  logic                   alu_xfer_s;
  logic                   issue_xfer_s;
  logic                   issue_rdy_s;
  logic                   wen_nxt_s;
  logic [REG_INX_WTH-1:0] idx_nxt_s;
  logic [WORD_WTH-1:0]    dat_nxt_s;

  // The long-latency channel is always accepted. The ALU stalls whenever it collides.
  assign lng_wbck_ready  = 1'b1;
  assign alu_wbck_ready  = ~lng_wbck_valid;
  assign lng_issue_ready = issue_rdy_s;
  assign lng_ostd_cnt    = cnt_r;

  // Decode handshakes for this cycle. At most one result transfer occurs, long-latency first.
  always_comb begin
    issue_rdy_s  = (cnt_r < CNT_LIMIT) & ~pend_hit(pending_r, lng_issue_idx);
    lng_xfer_s   = lng_wbck_valid;
    alu_xfer_s   = alu_wbck_valid & ~lng_wbck_valid;
    issue_xfer_s = lng_issue_valid & issue_rdy_s;
  end

  // Scoreboard update. An issue and a result on the same register in one cycle leaves it pending.
  always_comb begin
    set_vec_s = {REG_NUM{1'b0}};
    clr_vec_s = {REG_NUM{1'b0}};
    for (int i = 0; i < REG_NUM; i++) begin
      set_vec_s[i] = issue_xfer_s & (lng_issue_idx == REG_INX_WTH'(i));
      clr_vec_s[i] = lng_xfer_s & (lng_wbck_idx == REG_INX_WTH'(i));
    end
    pending_nxt_s    = (pending_r & ~clr_vec_s) | set_vec_s;
    pending_nxt_s[0] = 1'b0;
  end

  // Outstanding counter update.
  // An issue and a result in the same cycle cancel out.
  // A stray result while the counter is zero saturates at zero.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({issue_xfer_s, lng_xfer_s})
      2'b10: cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01: begin
        if (cnt_r == {CNT_WTH{1'b0}}) begin
          cnt_nxt_s = {CNT_WTH{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Write-port source select.
  // A transfer to x0 completes the handshake but does not write the register file.
  // With no transfer, idx/dat keep their last values.
  always_comb begin
    wen_nxt_s = 1'b0;
    idx_nxt_s = wbck_dest_idx;
    dat_nxt_s = wbck_dest_dat;
    if (lng_xfer_s) begin
      wen_nxt_s = (lng_wbck_idx != IDX_ZERO);
      idx_nxt_s = lng_wbck_idx;
      dat_nxt_s = lng_wbck_dat;
    end else if (alu_xfer_s) begin
      wen_nxt_s = (alu_wbck_idx != IDX_ZERO);
      idx_nxt_s = alu_wbck_idx;
      dat_nxt_s = alu_wbck_dat;
    end else begin
      wen_nxt_s = 1'b0;
    end
  end

  // Decode stalls on any operand whose long-latency producer is still in flight.
  // The registered write in flight is bypassed by the regfile, so it is not a hazard.
  assign chk_hazard = pend_hit(pending_r, chk_src1_idx)
                    | pend_hit(pending_r, chk_src2_idx)
                    | pend_hit(pending_r, chk_dest_idx);

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {REG_NUM{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Outstanding long-latency op counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_WTH{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Registered regfile write port. Reset drops any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbck_dest_wen <= 1'b0;
      wbck_dest_idx <= IDX_ZERO;
      wbck_dest_dat <= {WORD_WTH{1'b0}};
    end else begin
      wbck_dest_wen <= wen_nxt_s;
      wbck_dest_idx <= idx_nxt_s;
      wbck_dest_dat <= dat_nxt_s;
    end
  end

endmodule
